// File: rtl/onewire_pkg.sv
// Shared types and timing constants for the 1-wire master sequencer.
// All event times are in eighths of a time slot (E), counted from the
// command accept edge.
package onewire_pkg;

    typedef enum logic [2:0] {IDLE, LOW, REL, SMP, REC} owm_state_t;

    localparam logic [6:0] E_W1_REL  = 7'd1;    // write-1 / read slot release
    localparam logic [6:0] E_SMP     = 7'd4;    // bit slot sample point
    localparam logic [6:0] E_W0_REL  = 7'd10;   // write-0 slot release
    localparam logic [6:0] E_SLOT    = 7'd12;   // bit slot end
    localparam logic [6:0] E_RST_REL = 7'd64;   // reset pulse release (8 TS)
    localparam logic [6:0] E_PRS_SMP = 7'd80;   // presence sample point
    localparam logic [6:0] E_RST_END = 7'd112;  // reset cycle end

endpackage

// File: rtl/onewire_tick.sv
// Tick prescaler: counts 0..DIV-1 and asserts tick during the DIV-1 cycle.
// DIV is CDR_O when sel_ovd is set, CDR_N otherwise. clr restarts the count.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   clr         restart prescaler at 0 (command accept)
//   sel_ovd     1 = overdrive divider
//   tick        one-clock pulse per 1/8 time slot
module onewire_tick #(
    parameter int CDR_N = 4,
    parameter int CDR_O = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic sel_ovd,
    output logic tick
);

    localparam int DMAX = (CDR_N > CDR_O) ? CDR_N : CDR_O;
    // A divider of 1 would give a zero-width counter; keep at least one bit.
    localparam int CW   = (DMAX > 1) ? $clog2(DMAX) : 1;
    localparam logic [CW-1:0] LAST_N = CW'(CDR_N - 1);
    localparam logic [CW-1:0] LAST_O = CW'(CDR_O - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] last;

    assign last = sel_ovd ? LAST_O : LAST_N;
    assign tick = (cnt == last);

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/onewire_master_seq.sv
// 1-wire bus master sequencer. Runs one reset/presence cycle or one bit slot
// per accepted command and returns a single response bit.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cmd_vld/cmd_rdy                 command handshake (ready only when idle)
//   cmd_rst, cmd_dat, cmd_ovd       reset cycle / slot data / overdrive
//   rsp_vld, rsp_dat, rsp_err       one-clock response with data and stuck flag
//   owr_oe                          1 = pull the bus low
//   owr_i                           raw (asynchronous) bus input
module onewire_master_seq
    import onewire_pkg::*;
#(
    parameter int CDR_N = 4,
    parameter int CDR_O = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_vld,
    output logic cmd_rdy,
    input  logic cmd_rst,
    input  logic cmd_dat,
    input  logic cmd_ovd,
    output logic rsp_vld,
    output logic rsp_dat,
    output logic rsp_err,
    output logic owr_oe,
    input  logic owr_i
);

    owm_state_t state, state_nxt;

    logic [1:0] sync_q;
    logic       owr_s;
    logic       rst_q, dat_q, ovd_q, err_q, smp_q;
    logic [6:0] ecnt, ecnt_inc;
    logic [6:0] e_rel, e_smp, e_end;
    logic       tick, accept, smp_early, done;

    assign owr_s    = sync_q[1];
    // Idle clock after each response keeps back-to-back commands apart.
    assign cmd_rdy  = (state == IDLE) && !rsp_vld;
    assign accept   = cmd_vld && cmd_rdy;
    assign owr_oe   = (state == LOW);

    assign ecnt_inc = ecnt + 7'd1;
    assign e_rel    = rst_q ? E_RST_REL : (dat_q ? E_W1_REL : E_W0_REL);
    assign e_smp    = rst_q ? E_PRS_SMP : E_SMP;
    assign e_end    = rst_q ? E_RST_END : E_SLOT;

    // Write-0 slot still drives the line at the sample point; take the sample
    // in LOW so the slot can go straight to REC at release.
    assign smp_early = (state == LOW) && tick && (ecnt_inc == e_smp);
    assign done      = (state == REC) && tick && (ecnt_inc == e_end);

    onewire_tick #(.CDR_N(CDR_N), .CDR_O(CDR_O)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .sel_ovd (ovd_q),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = LOW;
            LOW:  if (tick && ecnt_inc == e_rel)
                      state_nxt = (rst_q || dat_q) ? REL : REC;
            REL:  if (tick && ecnt_inc == e_smp) state_nxt = SMP;
            SMP:  state_nxt = REC;
            REC:  if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;   // idle bus level, avoids a false stuck flag
            rst_q   <= 1'b0;
            dat_q   <= 1'b0;
            ovd_q   <= 1'b0;
            err_q   <= 1'b0;
            smp_q   <= 1'b0;
            ecnt    <= '0;
            rsp_vld <= 1'b0;
            rsp_dat <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], owr_i};
            if (accept) begin
                rst_q <= cmd_rst;
                dat_q <= cmd_dat;
                ovd_q <= cmd_ovd;
                err_q <= ~owr_s;
                ecnt  <= '0;
            end else if (state != IDLE && tick) begin
                ecnt  <= ecnt_inc;
            end
            if (state == SMP || smp_early)
                smp_q <= owr_s;
            rsp_vld <= done;
            if (done) begin
                // Presence is an active-low answer from the slave.
                rsp_dat <= rst_q ? ~smp_q : smp_q;
                rsp_err <= err_q;
            end
        end
    end

endmodule
